// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick adapter: latches two player words on a host load
// pulse and shifts them out on JOY_DATA like a 74HC165 chain.
module joy_db15_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PLAYER_BITS = 16
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   JOY_CLK,
  input  logic                   JOY_LOAD,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  output logic                   JOY_DATA,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [5:0]             bit_cnt
);

  localparam int             FRAME_BITS = 2 * PLAYER_BITS;
  localparam logic [5:0]     LAST_BIT   = 6'(FRAME_BITS - 1);
  localparam logic [5:0]     CNT_MAX    = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   sr;
  logic [SYNC_STAGES-1:0]  clk_sync;
  logic [SYNC_STAGES-1:0]  load_sync;
  logic                    clk_prev;
  logic                    clk_rise;
  logic                    load_active;

  // NOTE: synchroniser flops reset to 1 so the idle-high lines never look
  // like a load or a shift edge right after reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      clk_sync  <= '1;
      load_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      load_sync <= {load_sync[SYNC_STAGES-2:0], JOY_LOAD};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // clk_prev holds the previous value of the last stage for edge detection.
  assign clk_rise    = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign load_active = ~load_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      sr         <= '1;
      bit_cnt    <= '0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Load has priority over a coincident shift edge, as on a 74HC165.
      if (load_active) begin
        state   <= LOAD;
        sr      <= {~joystick2, ~joystick1};
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: state <= SHIFT;
          SHIFT: begin
            if (clk_rise) begin
              sr      <= {1'b1, sr[FRAME_BITS-1:1]};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == LAST_BIT) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DONE: begin
            if (clk_rise) begin
              sr      <= '1;
              overrun <= 1'b1;
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // sr is all ones in IDLE and DONE, so the line idles high there.
  assign JOY_DATA = sr[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: expected wire bits are queued at each load
// and popped as the host-side shift edges are issued.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        jclk;
  logic        jload;
  logic [15:0] j1;
  logic [15:0] j2;
  logic        jdata;
  logic        frame_done;
  logic        overrun;
  logic [5:0]  bit_cnt;

  int   tests    = 0;
  int   fails    = 0;
  int   fd_count = 0;
  int   last_chg;
  int   last_fd;
  int   fd_base;
  logic exp_q[$];

  joy_db15_tx #(.SYNC_STAGES(2), .PLAYER_BITS(16)) dut (
    .clk       (clk),
    .RESET     (rst),
    .JOY_CLK   (jclk),
    .JOY_LOAD  (jload),
    .joystick1 (j1),
    .joystick2 (j2),
    .JOY_DATA  (jdata),
    .frame_done(frame_done),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag);
    logic e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
    check(tag, {31'd0, jdata}, {31'd0, e});
  endtask

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(~a[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(~b[i]);
  endtask

  // One host shift clock: 10 clk high, 10 clk low; records when JOY_DATA
  // first changed and when frame_done was first seen (0 = never).
  task automatic rise();
    logic prev;
    prev     = jdata;
    last_chg = 0;
    last_fd  = 0;
    jclk     = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (last_chg == 0 && jdata !== prev) last_chg = j;
      if (last_fd == 0 && frame_done === 1'b1) last_fd = j;
      if (j == 10) jclk = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] b, input int n);
    j1 = a;
    j2 = b;
    push_frame(a, b);
    jload = 1'b0;
    repeat (n) @(negedge clk);
    jload = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    jclk  = 1'b0;
    jload = 1'b1;
    j1    = '0;
    j2    = '0;

    // Reset held with JOY_CLK toggling, then idle edges ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_data%0d", i), {31'd0, jdata}, 32'd1);
      check($sformatf("rst_cnt%0d", i), {26'd0, bit_cnt}, 32'd0);
      jclk = ~jclk;
    end
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst  = 1'b0;
    jclk = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rise();
      check($sformatf("idle_data%0d", i), {31'd0, jdata}, 32'd1);
      check($sformatf("idle_cnt%0d", i), {26'd0, bit_cnt}, 32'd0);
    end
    check("idle_fd_count", fd_count, 0);

    // Basic frame
    fd_base = fd_count;
    do_load(16'h0005, 16'h8000, 10);
    check("basic_cnt0", {26'd0, bit_cnt}, 32'd0);
    check_bit("basic_bit0");
    for (int e = 1; e <= 32; e++) begin
      rise();
      check_bit($sformatf("basic_bit%0d", e));
      if (e == 1 || e == 2) check($sformatf("latency_edge%0d", e), last_chg, 3);
      if (e < 32) check($sformatf("basic_nofd%0d", e), last_fd, 0);
    end
    check("basic_fd_delay", last_fd, 3);
    check("basic_fd_once", fd_count - fd_base, 1);
    check("basic_cnt32", {26'd0, bit_cnt}, 32'd32);
    check("basic_overrun", {31'd0, overrun}, 32'd0);

    // Input change mid-frame does not alter the latched frame
    fd_base = fd_count;
    do_load(16'h0001, 16'h0000, 6);
    check_bit("mid_bit0");
    for (int e = 1; e <= 32; e++) begin
      rise();
      if (e == 4) j1 = 16'hFFFF;
      check_bit($sformatf("mid_bit%0d", e));
    end
    check("mid_cnt", {26'd0, bit_cnt}, 32'd32);
    check("mid_fd_once", fd_count - fd_base, 1);

    // Overrun: 34 edges after one load
    fd_base = fd_count;
    do_load(16'hA5A5, 16'h3C3C, 4);
    check_bit("ovr_bit0");
    for (int e = 1; e <= 34; e++) begin
      rise();
      check_bit($sformatf("ovr_bit%0d", e));
      if (e == 32) check("ovr_clear_at32", {31'd0, overrun}, 32'd0);
    end
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_cnt34", {26'd0, bit_cnt}, 32'd34);
    check("ovr_fd_once", fd_count - fd_base, 1);
    jload = 1'b0;
    repeat (6) @(negedge clk);
    check("ovr_sticky_on_load", {31'd0, overrun}, 32'd1);
    check("ovr_load_cnt0", {26'd0, bit_cnt}, 32'd0);
    jload = 1'b1;
    repeat (5) @(negedge clk);

    // Collision: load falls together with a JOY_CLK rising edge
    j1 = 16'h00A5;
    j2 = 16'h0000;
    push_frame(j1, j2);
    jload = 1'b0;
    jclk  = 1'b1;
    repeat (10) @(negedge clk);
    check("coll_cnt", {26'd0, bit_cnt}, 32'd0);
    check("coll_data", {31'd0, jdata}, 32'd0);
    jclk = 1'b0;
    repeat (5) @(negedge clk);
    jload = 1'b1;
    repeat (5) @(negedge clk);
    check("coll_cnt_after", {26'd0, bit_cnt}, 32'd0);
    check_bit("coll_bit0");
    for (int e = 1; e <= 7; e++) begin
      rise();
      check_bit($sformatf("coll_bit%0d", e));
    end
    check("coll_cnt7", {26'd0, bit_cnt}, 32'd7);

    // Reset mid-frame aborts; later edges ignored until a new load
    fd_base = fd_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", {31'd0, jdata}, 32'd1);
    check("midrst_cnt", {26'd0, bit_cnt}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    for (int e = 1; e <= 5; e++) begin
      rise();
      check($sformatf("midrst_edge_cnt%0d", e), {26'd0, bit_cnt}, 32'd0);
      check($sformatf("midrst_edge_data%0d", e), {31'd0, jdata}, 32'd1);
    end
    check("midrst_no_fd", fd_count - fd_base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
